// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - D-stage instruction info in, bypass selects and stall out
interface hazard_fwd_unit_if #(
  parameter int NRP = 2,
  parameter int AW  = 5
);
  logic [NRP*AW-1:0] ra_D;
  logic [NRP-1:0]    need_D;
  logic [NRP-1:0]    need_E;
  logic              store_D;
  logic [AW-1:0]     wa_D;
  logic [2:0]        wsrc_D;
  logic              md_D;
  logic              hilo_D;
  logic              flush;
  logic [NRP*3-1:0]  sel_D;
  logic [NRP*3-1:0]  sel_E;
  logic              sel_M;
  logic              stall;

  modport master (
    output ra_D, need_D, need_E, store_D, wa_D, wsrc_D, md_D, hilo_D, flush,
    input  sel_D, sel_E, sel_M, stall
  );

  modport slave (
    input  ra_D, need_D, need_E, store_D, wa_D, wsrc_D, md_D, hilo_D, flush,
    output sel_D, sel_E, sel_M, stall
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - hazard detection and bypass select for a 5-stage pipeline
// Tracks destination tags through E/M/W and a mult/div busy counter.
module hazard_fwd_unit #(
  parameter int NRP    = 2,
  parameter int AW     = 5,
  parameter int MD_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_unit_if.slave hif
);
  localparam logic [2:0] W_NONE = 3'd0;
  localparam logic [2:0] W_ALU  = 3'd1;
  localparam logic [2:0] W_LOAD = 3'd2;
  localparam logic [2:0] W_PC8  = 3'd3;
  localparam logic [2:0] W_HILO = 3'd4;
  localparam int         CW     = $clog2(MD_LAT + 1);

  logic [AW-1:0]     wa_e_q, wa_e_d, wa_m_q, wa_m_d, wa_w_q, wa_w_d;
  logic [2:0]        wsrc_e_q, wsrc_e_d, wsrc_m_q, wsrc_m_d, wsrc_w_q, wsrc_w_d;
  logic [NRP*AW-1:0] ra_e_q, ra_e_d;
  logic [AW-1:0]     ra1_m_q, ra1_m_d;
  logic              store_e_q, store_e_d, store_m_q, store_m_d;
  logic [CW-1:0]     md_cnt_q, md_cnt_d;

  logic [NRP*3-1:0]  sel_d, sel_e;
  logic              hazard, stall, adv;

  // Register $0 never matches; codes 5-7 behave as "no result".
  function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] wa,
                               input logic [2:0] ws);
    return (a != '0) && (ws inside {W_ALU, W_LOAD, W_PC8, W_HILO}) && (wa == a);
  endfunction

  always_comb begin
    sel_d  = '0;
    sel_e  = '0;
    hazard = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      logic [AW-1:0] ra_i, rae_i;
      logic e_hit, m_hit, w_hit, me_hit, we_hit;
      ra_i   = hif.ra_D[i*AW +: AW];
      rae_i  = ra_e_q[i*AW +: AW];
      e_hit  = hit(ra_i, wa_e_q, wsrc_e_q);
      m_hit  = hit(ra_i, wa_m_q, wsrc_m_q);
      w_hit  = hit(ra_i, wa_w_q, wsrc_w_q);
      me_hit = hit(rae_i, wa_m_q, wsrc_m_q);
      we_hit = hit(rae_i, wa_w_q, wsrc_w_q);

      if (e_hit && wsrc_e_q == W_PC8)      sel_d[i*3 +: 3] = 3'd1;
      else if (m_hit && wsrc_m_q == W_ALU)  sel_d[i*3 +: 3] = 3'd2;
      else if (m_hit && wsrc_m_q == W_HILO) sel_d[i*3 +: 3] = 3'd3;
      else if (m_hit && wsrc_m_q == W_PC8)  sel_d[i*3 +: 3] = 3'd4;
      else if (w_hit)                       sel_d[i*3 +: 3] = 3'd5;

      if (me_hit && wsrc_m_q == W_ALU)       sel_e[i*3 +: 3] = 3'd2;
      else if (me_hit && wsrc_m_q == W_HILO) sel_e[i*3 +: 3] = 3'd3;
      else if (me_hit && wsrc_m_q == W_PC8)  sel_e[i*3 +: 3] = 3'd4;
      else if (we_hit)                       sel_e[i*3 +: 3] = 3'd5;

      // A value needed in D can only bypass PC8 from E or non-load results from M.
      if (hif.need_D[i] && ((e_hit && (wsrc_e_q inside {W_ALU, W_LOAD, W_HILO})) ||
                            (m_hit && wsrc_m_q == W_LOAD)))
        hazard = 1'b1;
      if (hif.need_E[i] && e_hit && wsrc_e_q == W_LOAD)
        hazard = 1'b1;
    end
    stall = !hif.flush && (hazard || ((hif.md_D || hif.hilo_D) && (md_cnt_q != '0)));
    adv   = !stall && !hif.flush;
  end

  always_comb begin
    wa_e_d    = '0;
    wsrc_e_d  = W_NONE;
    ra_e_d    = '0;
    store_e_d = 1'b0;
    if (adv) begin
      wa_e_d    = hif.wa_D;
      wsrc_e_d  = hif.wsrc_D;
      ra_e_d    = hif.ra_D;
      store_e_d = hif.store_D;
    end
    wa_m_d    = wa_e_q;
    wsrc_m_d  = wsrc_e_q;
    ra1_m_d   = ra_e_q[AW +: AW];
    store_m_d = store_e_q;
    wa_w_d    = wa_m_q;
    wsrc_w_d  = wsrc_m_q;
    md_cnt_d  = md_cnt_q;
    if (hif.md_D && adv)       md_cnt_d = CW'(MD_LAT);
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_e_q    <= '0;
      wsrc_e_q  <= W_NONE;
      ra_e_q    <= '0;
      store_e_q <= 1'b0;
      wa_m_q    <= '0;
      wsrc_m_q  <= W_NONE;
      ra1_m_q   <= '0;
      store_m_q <= 1'b0;
      wa_w_q    <= '0;
      wsrc_w_q  <= W_NONE;
      md_cnt_q  <= '0;
    end else begin
      wa_e_q    <= wa_e_d;
      wsrc_e_q  <= wsrc_e_d;
      ra_e_q    <= ra_e_d;
      store_e_q <= store_e_d;
      wa_m_q    <= wa_m_d;
      wsrc_m_q  <= wsrc_m_d;
      ra1_m_q   <= ra1_m_d;
      store_m_q <= store_m_d;
      wa_w_q    <= wa_w_d;
      wsrc_w_q  <= wsrc_w_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

  assign hif.sel_D = sel_d;
  assign hif.sel_E = sel_e;
  assign hif.sel_M = store_m_q && hit(ra1_m_q, wa_w_q, wsrc_w_q);
  assign hif.stall = stall;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed vectors with a queued scoreboard for hazard_fwd_unit
module tb_hazard_fwd_unit;
  localparam logic [2:0] NONE = 3'd0, ALU = 3'd1, LOAD = 3'd2, PC8 = 3'd3, HILO = 3'd4;
  localparam logic [13:0] MA    = 14'h3fff;
  localparam logic [13:0] MNSD0 = 14'h38ff;
  localparam logic [13:0] MNSD1 = 14'h07ff;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [13:0] exp_q[$];
  logic [13:0] msk_q[$];
  string       nam_q[$];
  event        chk_ev;

  hazard_fwd_unit_if #(.NRP(2), .AW(5)) hif ();

  hazard_fwd_unit #(.NRP(2), .AW(5), .MD_LAT(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ex(input logic [2:0] sd1, input logic [2:0] sd0,
                                     input logic [2:0] se1, input logic [2:0] se0,
                                     input logic sm, input logic st);
    return {sd1, sd0, se1, se0, sm, st};
  endfunction

  task automatic push(input string n, input logic [13:0] e, input logic [13:0] m);
    nam_q.push_back(n);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic drv(input logic [2:0] ws, input logic [4:0] wa, input logic [4:0] r0,
                     input logic [4:0] r1, input logic [1:0] nd, input logic [1:0] ne,
                     input logic st, input logic md, input logic hl);
    hif.wsrc_D  = ws;
    hif.wa_D    = wa;
    hif.ra_D    = {r1, r0};
    hif.need_D  = nd;
    hif.need_E  = ne;
    hif.store_D = st;
    hif.md_D    = md;
    hif.hilo_D  = hl;
    hif.flush   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle3();
    drv(NONE, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  logic [13:0] m_exp, m_msk, m_act;
  string       m_nam;

  always begin
    @(negedge clk or chk_ev);
    while (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_msk = msk_q.pop_front();
      m_nam = nam_q.pop_front();
      m_act = {hif.sel_D, hif.sel_E, hif.sel_M, hif.stall};
      n_tests++;
      if ((m_act & m_msk) !== (m_exp & m_msk)) begin
        n_fail++;
        $display("FAIL %s: got {sel_D,sel_E,sel_M,stall}=%h want %h (mask %h)",
                 m_nam, m_act, m_exp, m_msk);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drv(HILO, 5, 5, 5, 2'b01, 0, 1, 1, 1);
    #2;
    push("rst_t0", 0, MA);
    ->chk_ev;
    #10;
    rst_n = 1'b1;
    idle3();

    // ALU chain
    drv(ALU, 8, 0, 0, 0, 0, 0, 0, 0);     push("alu_issue", 0, MA); step();
    drv(NONE, 0, 8, 0, 0, 2'b01, 0, 0, 0); push("alu_rd1_d", 0, MNSD0); step();
    drv(NONE, 0, 8, 0, 0, 2'b01, 0, 0, 0); push("alu_rd1_e", ex(0,0,0,2,0,0), MNSD0); step();
    drv(NONE, 0, 0, 0, 0, 0, 0, 0, 0);     push("alu_rd2_e", ex(0,0,0,5,0,0), MA); step();
    idle3();

    // load-use
    drv(LOAD, 9, 0, 0, 0, 0, 0, 0, 0);     push("ld_issue", 0, MA); step();
    drv(NONE, 0, 0, 9, 0, 2'b10, 0, 0, 0); push("ld_use_stall", ex(0,0,0,0,0,1), MNSD1); step();
    push("ld_use_release", 0, MNSD1); step();
    drv(NONE, 0, 0, 0, 0, 0, 0, 0, 0);     push("ld_use_e", ex(0,0,5,0,0,0), MA); step();
    idle3();

    // branch after jal and ALU
    drv(PC8, 31, 0, 0, 0, 0, 0, 0, 0);        push("jal_issue", 0, MA); step();
    drv(NONE, 0, 31, 0, 2'b01, 0, 0, 0, 0);   push("br_pc8_e", ex(0,1,0,0,0,0), MA); step();
    drv(ALU, 31, 0, 31, 2'b10, 0, 0, 0, 0);   push("alu_pc8_m", ex(4,0,0,4,0,0), MA); step();
    drv(NONE, 0, 31, 0, 2'b01, 0, 0, 0, 0);   push("br_alu_stall", ex(0,5,5,0,0,1), MA); step();
    push("br_alu_m", ex(0,2,0,0,0,0), MA); step();
    idle3();

    // HILO forwarding
    drv(HILO, 7, 0, 0, 0, 0, 0, 0, 0);        push("mfhi_issue", 0, MA); step();
    drv(NONE, 0, 0, 7, 0, 2'b10, 0, 0, 0);    push("mfhi_use_d", 0, MNSD1); step();
    drv(NONE, 0, 7, 0, 2'b01, 0, 0, 0, 0);    push("mfhi_fwd", ex(0,3,3,0,0,0), MA); step();
    idle3();

    // store after load
    drv(LOAD, 4, 0, 0, 0, 0, 0, 0, 0);        push("st_ld_issue", 0, MA); step();
    drv(NONE, 0, 0, 4, 0, 0, 1, 0, 0);        push("st_no_stall", 0, MA); step();
    drv(NONE, 0, 0, 0, 0, 0, 0, 0, 0);        push("st_in_e", 0, MA); step();
    push("st_in_m", ex(0,0,0,0,1,0), MA); step();
    idle3();

    // writes to $0 never forward
    drv(ALU, 0, 0, 0, 0, 0, 0, 0, 0);         push("z_issue", 0, MA); step();
    drv(NONE, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0); push("z_e", 0, MA); step();
    push("z_m", 0, MA); step();
    idle3();

    // flush kills D and suppresses stall
    drv(LOAD, 3, 0, 0, 0, 0, 0, 0, 0);        push("fl_ld_issue", 0, MA); step();
    drv(ALU, 6, 3, 0, 0, 2'b01, 0, 0, 0);
    hif.flush = 1'b1;                          push("fl_no_stall", 0, MNSD0); step();
    drv(NONE, 0, 6, 0, 2'b01, 0, 0, 0, 0);    push("fl_bubble", 0, MA); step();
    idle3();

    // mult/div busy then hilo access
    drv(NONE, 0, 0, 0, 0, 0, 0, 1, 0);        push("md_issue", 0, MA); step();
    for (int k = 1; k <= 6; k++) begin
      drv(NONE, 0, 0, 0, 0, 0, 0, 0, 1);
      push($sformatf("md_hilo_c%0d", k), ex(0,0,0,0,0,(k <= 5)), MA);
      step();
    end

    // a stalled mult/div must not reload the counter
    drv(NONE, 0, 0, 0, 0, 0, 0, 1, 0);        push("md2_issue", 0, MA); step();
    for (int k = 1; k <= 6; k++) begin
      drv(NONE, 0, 0, 0, 0, 0, 0, 1, 0);
      push($sformatf("md2_retry_c%0d", k), ex(0,0,0,0,0,(k <= 5)), MA);
      step();
    end
    drv(NONE, 0, 0, 0, 0, 0, 0, 0, 1);        push("md2_reloaded", ex(0,0,0,0,0,1), MA); step();
    drv(NONE, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // asynchronous reset mid mult/div
    drv(ALU, 8, 0, 0, 0, 0, 0, 0, 0);         push("rm_alu", 0, MA); step();
    drv(NONE, 0, 0, 0, 0, 0, 0, 1, 0);        push("rm_md", 0, MA); step();
    drv(NONE, 0, 8, 0, 2'b01, 0, 0, 0, 1);    push("rm_pre", ex(0,2,0,0,0,1), MA);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push("rm_async", 0, MA);
    ->chk_ev;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drv(ALU, 8, 0, 0, 0, 0, 0, 0, 1);
    #1;
    push("rm_busy_clear", 0, MA);
    ->chk_ev;
    step();
    drv(NONE, 0, 8, 0, 2'b01, 0, 0, 0, 0);    push("rm_first_edge", ex(0,0,0,0,0,1), MA); step();
    drv(NONE, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter NRP, default 2: number of decode-stage register read ports; shall be >= 2, and port 1 is the rt/store-data port.
REQ-002 Parameter AW, default 5: register address width.
REQ-003 Parameter MD_LAT, default 5: mult/div busy cycles; shall be >= 1.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port ra_D, input, NRP*AW bits: D-stage read addresses; port i occupies bits [i*AW +: AW].
REQ-007 Port need_D, input, NRP bits: port value is consumed in D (branch compare or jr).
REQ-008 Port need_E, input, NRP bits: port value is consumed in E (ALU operand).
REQ-009 Port store_D, input, 1 bit: port-1 value is consumed in M as store data.
REQ-010 Port wa_D, input, AW bits: D-stage destination register.
REQ-011 Port wsrc_D, input, 3 bits: result source; 0 none, 1 ALU, 2 LOAD, 3 PC8, 4 HILO (mfhi/mflo); 5-7 are treated as none.
REQ-012 Port md_D, input, 1 bit: D instruction starts a mult/div.
REQ-013 Port hilo_D, input, 1 bit: D instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo).
REQ-014 Port flush, input, 1 bit: the D instruction is killed and a bubble enters E.
REQ-015 Port sel_D, output, NRP*3 bits: D bypass select per port; 0 regfile, 1 PC8_E, 2 ALU_M, 3 HILO_M, 4 PC8_M, 5 WtDt.
REQ-016 Port sel_E, output, NRP*3 bits: E bypass select per port; codes 0, 2, 3, 4, 5 only.
REQ-017 Port sel_M, output, 1 bit: 1 selects WtDt as store data, 0 selects the pipelined rt value.
REQ-018 Port stall, output, 1 bit: hold PC and D, and inject a bubble into E.

Function
REQ-019 The block shall keep registered tag stages E, M and W, each holding wa, wsrc, the NRP read addresses, need_E bits and the store bit; W holds wa and wsrc only.
REQ-020 Each edge without stall or flush shall advance D->E->M->W.
REQ-021 On stall or flush, E shall load a bubble (wsrc=0, need and store bits 0) while M and W still advance.
REQ-022 A stage "matches" address a when a != 0, the stage wsrc is not none, and the stage wa == a; address 0 never matches.
REQ-023 sel_D[i] priority shall be youngest first: E match with PC8 -> 1; else M match with ALU -> 2, HILO -> 3, PC8 -> 4; else W match -> 5; else 0.
REQ-024 sel_E[i] priority shall be: M-stage match with ALU -> 2, HILO -> 3, PC8 -> 4; else W match -> 5; else 0; the address is the E-stage registered address.
REQ-025 sel_M shall be 1 iff the M-stage store bit is 1 and W matches the M-stage port-1 address.
REQ-026 The D hazard for port i with need_D[i]=1 shall be: E match with wsrc in {ALU, LOAD, HILO}, or M match with LOAD.
REQ-027 The D hazard for port i with need_E[i]=1 shall be: E match with LOAD.
REQ-028 Store data (store_D) shall never raise a hazard; it is resolved by sel_E/sel_M.
REQ-029 Busy counter md_cnt, width clog2(MD_LAT+1), shall load MD_LAT on an edge where md_D=1 and stall=0 and flush=0; otherwise it shall decrement while non-zero; busy = (md_cnt != 0).
REQ-030 stall = any D hazard OR ((md_D OR hilo_D) AND busy); stall shall be ignored (forced 0) when flush=1.
REQ-031 Simultaneous stall and an md_D request shall not load md_cnt; the request is retried after the stall.
REQ-032 sel_D, sel_E, sel_M and stall shall be combinational from stage registers and D inputs, with zero-cycle latency.
REQ-033 When a port needs its value in E, sel_D[i] may be any legal code, because the datapath ignores it.

Reset
REQ-034 rst_n=0 shall immediately clear all stage registers (wsrc=0, addresses 0, bits 0) and md_cnt, independent of clk.
REQ-035 With state cleared, sel_E=0, sel_M=0 and stall=0 shall hold, and sel_D=0 regardless of D inputs.
REQ-036 Reset asserted mid mult/div shall clear busy in the same cycle.
REQ-037 The first edge after rst_n rises shall advance normally.

Verification
REQ-038 Scenario ALU chain: ALU wa=8, then a reader with ra_D[0]=8 and need_E=1 -> next cycle sel_E[0]=2; a reader one instruction later gets sel_E[0]=5; stall=0 throughout.
REQ-039 Scenario load-use: LOAD wa=9 in E while D has ra_D[1]=9 and need_E[1]=1 -> stall=1 for exactly 1 cycle; the reader then reaches E with sel_E[1]=5.
REQ-040 Scenario branch after jal and ALU: E holds PC8 wa=31 and D has ra_D[0]=31 with need_D -> sel_D[0]=1, stall=0; E holds ALU wa=31 -> stall=1 for 1 cycle, then sel_D[0]=2.
REQ-041 Scenario mult/div: md_D at cycle 0 (MD_LAT=5), hilo_D held from cycle 1 -> stall=1 in cycles 1-5, 0 in cycle 6.
REQ-042 Scenario store after load: LOAD wa=4, then store_D with ra_D[1]=4 -> stall never asserts; sel_M=1 when the store is in M.
REQ-043 Scenario $0 and reset: an ALU writing wa=0 followed by a reader of 0 -> all sels 0; rst_n pulsed low mid-sequence -> outputs 0 and md_cnt=0 without a clock edge.
